// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO registers and pipeline stall
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mfResult
);
  localparam int CW = $clog2(ITER);
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MTLO = 6'h13;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] dvs, ma, mb, quo, rem;
  logic [WIDTH:0] mul_sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic neg, rneg, dz, is_d, go, is_mul, is_div, sgn, hilo, last;
  assign busy = state != IDLE;
  assign go = valid && state == IDLE;
  assign is_mul = funct == 6'h18 || funct == 6'h19;
  assign is_div = funct == 6'h1A || funct == 6'h1B;
  assign sgn = ~funct[0];
  assign hilo = funct[5:2] == 4'b0100 || funct[5:2] == 4'b0110;
  assign stall = busy && valid && hilo;
  assign mfResult = funct == MFHI ? hi : lo;
  assign last = cnt == CW'(ITER - 1);
  always_comb begin
    ma = sgn && inputA[WIDTH-1] ? -inputA : inputA;
    mb = sgn && inputB[WIDTH-1] ? -inputB : inputB;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? dvs : {WIDTH{1'b0}}};
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs};
    prod = neg ? -acc : acc;
    quo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    next = state == IDLE ? (go && is_mul ? MUL : go && is_div ? DIV : IDLE)
         : (state == MUL || state == DIV) ? (last ? FIX : state) : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  // {hi-half, lo-half} of acc holds {partial product, multiplier} or {remainder, quotient}
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      dvs <= '0;
      {neg, rneg, dz, is_d} <= '0;
      hi <= '0;
      lo <= '0;
    end else if (state == IDLE) begin
      if (go && (is_mul || is_div)) begin
        acc <= {{WIDTH{1'b0}}, ma};
        dvs <= mb;
        neg <= sgn && (inputA[WIDTH-1] ^ inputB[WIDTH-1]);
        rneg <= sgn && inputA[WIDTH-1];
        dz <= inputB == '0;
        is_d <= is_div;
        cnt <= '0;
      end
      if (go && funct == MTHI) hi <= inputA;
      if (go && funct == MTLO) lo <= inputA;
    end else if (state == MUL) begin
      acc <= {mul_sum, acc[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end else if (state == DIV) begin
      acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      cnt <= cnt + CW'(1);
    end else if (is_d) begin
      // divide by zero leaves the dividend magnitude as remainder, so rneg restores raw inputA
      lo <= dz ? {WIDTH{1'b1}} : quo;
      hi <= rem;
    end else begin
      {hi, lo} <= prod;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for the multi-cycle MULT/DIV engine
module tb_muldiv_sequencer;
  logic clk = 0, reset = 1, valid = 0;
  logic [5:0] funct = 0;
  logic [31:0] inputA = 0, inputB = 0;
  logic stall, busy;
  logic [31:0] hi, lo, mfResult;
  int vectors = 0, errors = 0;
  logic [63:0] sb[$];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .valid(valid), .funct(funct), .inputA(inputA),
    .inputB(inputB), .stall(stall), .busy(busy), .hi(hi), .lo(lo), .mfResult(mfResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb_, q, r;
    logic signed [63:0] sp;
    sa = a;
    sb_ = b;
    if (f == 6'h19) return {32'b0, a} * {32'b0, b};
    if (f == 6'h18) begin
      sp = 64'(sa) * 64'(sb_);
      return sp;
    end
    if (b == 0) return {a, 32'hFFFFFFFF};
    if (f == 6'h1B) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = sa / sb_;
    r = sa % sb_;
    return {r, q};
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = 1;
    funct = f;
    inputA = a;
    inputB = b;
    @(posedge clk);
    #1;
    valid = 0;
    funct = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 100) break;
      n++;
    end
  endtask

  task automatic finish_op(input string tag, input int n);
    logic [63:0] e;
    chk({tag, " latency"}, n, 33);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " hi"}, hi, e[63:32]);
    chk({tag, " lo"}, lo, e[31:0]);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    sb.push_back(model(f, a, b));
    issue(f, a, b);
    wait_idle(n);
    finish_op(tag, n);
  endtask

  initial begin
    int n, bad;
    logic [5:0] f;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset stall", stall, 0);

    run_op("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu max hi const", hi, 32'hFFFFFFFE);

    sb.push_back(model(6'h18, 32'hFFFFFFFD, 7));
    issue(6'h18, 32'hFFFFFFFD, 7);
    valid = 1;
    funct = 6'h12;
    bad = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n > 100) break;
      if (stall !== 1'b1) bad++;
      n++;
    end
    chk("mflo stall held", bad, 0);
    chk("mflo stall released", stall, 0);
    chk("mflo result", mfResult, 32'hFFFFFFEB);
    valid = 0;
    finish_op("mult neg", n);

    run_op("div -7/2", 6'h1A, 32'hFFFFFFF9, 2);
    run_op("divu by 0", 6'h1B, 100, 0);
    run_op("div by 0 neg", 6'h1A, 32'hFFFFFF00, 0);

    sb.push_back(model(6'h1A, 32'h80000000, 32'hFFFFFFFF));
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    valid = 1;
    funct = 6'h11;
    inputA = 32'h1234;
    @(negedge clk);
    chk("mthi stall", stall, 1);
    valid = 1;
    funct = 6'h20;
    #1 chk("add no stall", stall, 0);
    funct = 6'h11;
    n = 1;
    forever begin
      @(negedge clk);
      if (!busy || n > 100) break;
      n++;
    end
    finish_op("div ovf", n);
    @(posedge clk);
    #1 valid = 0;
    funct = 0;
    @(negedge clk);
    chk("mthi applied", hi, 32'h1234);
    chk("mthi lo kept", lo, 32'h80000000);

    issue(6'h13, 32'hABCD, 0);
    @(negedge clk);
    chk("mtlo busy", busy, 0);
    chk("mtlo lo", lo, 32'hABCD);

    issue(6'h18, 5, 6);
    repeat (10) @(posedge clk);
    #1 reset = 1;
    valid = 1;
    funct = 6'h10;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort stall", stall, 0);
    valid = 0;
    run_op("multu 3x4", 6'h19, 3, 4);
    chk("multu 3x4 lo const", lo, 12);

    funct = 6'h18;
    inputA = 9;
    inputB = 9;
    repeat (3) @(negedge clk);
    chk("invalid no start", busy, 0);
    funct = 0;

    run_op("b2b mult a", 6'h18, 32'hFFFF0001, 32'h7FFFFFFF);
    run_op("b2b mult b", 6'h18, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 8; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      run_op("random", f, $urandom, (i == 5) ? 32'h0 : ((i & 1) ? $urandom : 32'($urandom_range(1, 1000))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
